adc_sample_serializer: RTL and testbench



---
 rtl/adc_ser_pkg.sv | 18 +
 rtl/adc_sample_serializer_fifo.sv | 53 +++++
 rtl/adc_sample_serializer.sv | 124 ++++++++++++
 tb/tb_adc_sample_serializer.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_ser_pkg.sv
// Shared definitions for the ADC sample serializer: staging states, entry width
// and default parameter values.
package adc_ser_pkg;

  localparam int DEF_W_DATA = 18;
  localparam int DEF_W_CHAN = 3;
  localparam int DEF_N_CHAN = 8;
  localparam int DEF_DEPTH  = 8;
  localparam int DEF_W_CNT  = 8;

  localparam int W_ENTRY = DEF_W_CHAN + DEF_W_DATA;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_PUSH_B = 1'b1
  } stage_state_t;

endpackage

// File: rtl/adc_sample_serializer_fifo.sv
// First-word fall-through synchronous FIFO; a write into a full FIFO is taken
// only when a read retires the head entry in the same cycle.
module sync_fifo_fwft
  import adc_ser_pkg::*;
#(
  parameter int width = W_ENTRY,
  parameter int depth = DEF_DEPTH
) (
  input  logic                     clk_in,
  input  logic                     n_reset_in,
  input  logic                     wr_en,
  input  logic [width-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [width-1:0]         rd_data,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(depth):0]   count
);

  localparam int W_PTR = $clog2(depth);
  localparam logic [W_PTR:0] FULL_CNT = depth[W_PTR:0];

  logic [width-1:0] mem [depth];
  logic [W_PTR-1:0] wr_ptr, rd_ptr;
  logic             rd_ok, wr_ok;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign rd_ok   = rd_en & ~empty;
  assign wr_ok   = wr_en & (~full | rd_ok);
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk_in) begin
    if (wr_ok) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk_in) begin
    if (!n_reset_in) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/adc_sample_serializer.sv
// Serializes paired lane A/B ADC samples into one channel-tagged stream with
// channel masking, a FWFT output FIFO and saturating drop accounting.
//   state     | meaning
//   ST_IDLE   | waiting for a strobe; lane A pushed on dv_in, lane B held
//   ST_PUSH_B | pushing held lane B; a dv_in here is an overrun
module adc_sample_serializer
  import adc_ser_pkg::*;
#(
  parameter int W_DATA = DEF_W_DATA,
  parameter int W_CHAN = DEF_W_CHAN,
  parameter int N_CHAN = DEF_N_CHAN,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int W_CNT  = DEF_W_CNT
) (
  input  logic              clk_in,
  input  logic              n_reset_in,
  input  logic              dv_in,
  input  logic [W_CHAN-1:0] chan_a_in,
  input  logic [W_CHAN-1:0] chan_b_in,
  input  logic [W_DATA-1:0] data_a_in,
  input  logic [W_DATA-1:0] data_b_in,
  input  logic [N_CHAN-1:0] chan_en_in,
  input  logic              ovf_clr_in,
  input  logic              ready_in,
  output logic              dv_out,
  output logic [W_CHAN-1:0] chan_out,
  output logic [W_DATA-1:0] data_out,
  output logic              ovf_out,
  output logic [W_CNT-1:0]  drop_cnt_out
);

  localparam int W_ENT  = W_CHAN + W_DATA;
  localparam int W_FCNT = $clog2(DEPTH) + 1;

  stage_state_t      state, state_nx;
  logic [W_CHAN-1:0] hold_chan, push_chan;
  logic [W_DATA-1:0] hold_data, push_data;
  logic              push_req, latch_b, ovr;
  logic              push_en, pop, wr_drop, wr_en;
  logic              fifo_empty, fifo_full;
  logic [W_FCNT-1:0] fifo_count;
  logic [W_ENT-1:0]  head, last_head;
  logic [1:0]        drop_inc;
  logic [W_CNT:0]    drop_sum;

  always_comb begin
    state_nx  = state;
    push_req  = 1'b0;
    latch_b   = 1'b0;
    ovr       = 1'b0;
    push_chan = chan_a_in;
    push_data = data_a_in;
    case (state)
      ST_IDLE: begin
        if (dv_in) begin
          push_req = 1'b1;
          latch_b  = 1'b1;
          state_nx = ST_PUSH_B;
        end
      end
      ST_PUSH_B: begin
        push_req  = 1'b1;
        push_chan = hold_chan;
        push_data = hold_data;
        ovr       = dv_in;
        state_nx  = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  assign push_en  = push_req & chan_en_in[push_chan];
  assign pop      = ~fifo_empty & ready_in;
  assign wr_drop  = push_en & fifo_full & ~pop;
  assign wr_en    = push_en & ~wr_drop;
  // overrun loses two samples, a full-FIFO push loses one
  assign drop_inc = {ovr, wr_drop};
  assign drop_sum = {1'b0, drop_cnt_out} + {{(W_CNT-1){1'b0}}, drop_inc};

  sync_fifo_fwft #(
    .width (W_ENT),
    .depth (DEPTH)
  ) u_fifo (
    .clk_in     (clk_in),
    .n_reset_in (n_reset_in),
    .wr_en      (wr_en),
    .wr_data    ({push_chan, push_data}),
    .rd_en      (pop),
    .rd_data    (head),
    .empty      (fifo_empty),
    .full       (fifo_full),
    .count      (fifo_count)
  );

  always_ff @(posedge clk_in) begin
    if (!n_reset_in) begin
      state        <= ST_IDLE;
      hold_chan    <= '0;
      hold_data    <= '0;
      last_head    <= '0;
      ovf_out      <= 1'b0;
      drop_cnt_out <= '0;
    end else begin
      state <= state_nx;
      if (latch_b) begin
        hold_chan <= chan_b_in;
        hold_data <= data_b_in;
      end
      if (fifo_count != '0) last_head <= head;
      if (ovf_clr_in) begin
        ovf_out      <= 1'b0;
        drop_cnt_out <= '0;
      end else if (drop_inc != 2'd0) begin
        ovf_out      <= 1'b1;
        drop_cnt_out <= drop_sum[W_CNT] ? '1 : drop_sum[W_CNT-1:0];
      end
    end
  end

  // the output keeps showing the last head once the FIFO drains
  assign dv_out               = ~fifo_empty;
  assign {chan_out, data_out} = fifo_empty ? last_head : head;

endmodule

// File: tb/tb_adc_sample_serializer.sv
// Scoreboard bench for adc_sample_serializer: a transaction-level model queues
// expected samples, a monitor compares every presented output.
module tb_adc_sample_serializer;

  localparam int W_DATA  = 18;
  localparam int W_CHAN  = 3;
  localparam int N_CHAN  = 8;
  localparam int DEPTH   = 8;
  localparam int W_CNT   = 8;
  localparam int CNT_MAX = (1 << W_CNT) - 1;

  typedef logic [W_CHAN+W_DATA-1:0] entry_t;

  logic              clk_in = 1'b0;
  logic              n_reset_in = 1'b0;
  logic              dv_in = 1'b0;
  logic [W_CHAN-1:0] chan_a_in = '0;
  logic [W_CHAN-1:0] chan_b_in = '0;
  logic [W_DATA-1:0] data_a_in = '0;
  logic [W_DATA-1:0] data_b_in = '0;
  logic [N_CHAN-1:0] chan_en_in = '1;
  logic              ovf_clr_in = 1'b0;
  logic              ready_in = 1'b1;
  logic              dv_out;
  logic [W_CHAN-1:0] chan_out;
  logic [W_DATA-1:0] data_out;
  logic              ovf_out;
  logic [W_CNT-1:0]  drop_cnt_out;

  always #5 clk_in = ~clk_in;

  adc_sample_serializer #(
    .W_DATA (W_DATA), .W_CHAN (W_CHAN), .N_CHAN (N_CHAN), .DEPTH (DEPTH), .W_CNT (W_CNT)
  ) dut (
    .clk_in       (clk_in),
    .n_reset_in   (n_reset_in),
    .dv_in        (dv_in),
    .chan_a_in    (chan_a_in),
    .chan_b_in    (chan_b_in),
    .data_a_in    (data_a_in),
    .data_b_in    (data_b_in),
    .chan_en_in   (chan_en_in),
    .ovf_clr_in   (ovf_clr_in),
    .ready_in     (ready_in),
    .dv_out       (dv_out),
    .chan_out     (chan_out),
    .data_out     (data_out),
    .ovf_out      (ovf_out),
    .drop_cnt_out (drop_cnt_out)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Reference model: samples waiting in the FIFO, a pending lane B, counters.
  entry_t exp_q[$];
  entry_t b_hold;
  entry_t m_e;
  entry_t last_exp = '0;
  int     occ = 0;
  int     m_cnt = 0;
  int     m_drops;
  bit     m_ovf = 0;
  bit     b_pend = 0;
  bit     m_pop, m_cand;

  always @(posedge clk_in) begin
    if (!n_reset_in) begin
      occ = 0; m_cnt = 0; m_ovf = 0; b_pend = 0;
    end else begin
      m_pop = (occ > 0) && ready_in;
      m_cand = 0; m_drops = 0; m_e = '0;
      if (b_pend) begin
        m_cand = 1; m_e = b_hold; b_pend = 0;
        if (dv_in) m_drops += 2;
      end else if (dv_in) begin
        m_cand = 1; m_e = {chan_a_in, data_a_in};
        b_hold = {chan_b_in, data_b_in}; b_pend = 1;
      end
      if (m_cand && chan_en_in[m_e[W_CHAN+W_DATA-1 -: W_CHAN]]) begin
        if (occ < DEPTH || m_pop) begin
          exp_q.push_back(m_e);
          occ++;
        end else m_drops++;
      end
      if (m_pop) occ--;
      if (ovf_clr_in) begin
        m_cnt = 0; m_ovf = 0;
      end else if (m_drops > 0) begin
        m_ovf = 1;
        m_cnt = (m_cnt + m_drops > CNT_MAX) ? CNT_MAX : m_cnt + m_drops;
      end
    end
  end

  always @(negedge clk_in) begin
    if (!n_reset_in) begin
      exp_q.delete();
      last_exp = '0;
    end else begin
      check("dv_out", dv_out, occ > 0);
      check("drop_cnt", drop_cnt_out, m_cnt);
      check("ovf", ovf_out, m_ovf);
      if (dv_out) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_out: got ch %0d data %0h, expected no sample", chan_out, data_out);
        end else begin
          check("head", {chan_out, data_out}, exp_q[0]);
          if (ready_in) last_exp = exp_q.pop_front();
        end
      end else begin
        check("idle_hold", {chan_out, data_out}, last_exp);
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge clk_in); #1; end
  endtask

  task automatic strobe(input logic [W_CHAN-1:0] ca, input logic [W_CHAN-1:0] cb);
    dv_in = 1; chan_a_in = ca; chan_b_in = cb;
    data_a_in = W_DATA'($urandom); data_b_in = W_DATA'($urandom);
    tick(); dv_in = 0; tick();
  endtask

  task automatic latency_strobe(input string tag, input logic [W_CHAN-1:0] ca, input logic [W_DATA-1:0] da,
                                input logic [W_CHAN-1:0] cb, input logic [W_DATA-1:0] db);
    dv_in = 1; chan_a_in = ca; data_a_in = da; chan_b_in = cb; data_b_in = db;
    tick(); dv_in = 0;
    @(negedge clk_in);
    check({tag, "_a_dv"}, dv_out, 1); check({tag, "_a_ch"}, chan_out, ca); check({tag, "_a_data"}, data_out, da);
    tick();
    @(negedge clk_in);
    check({tag, "_b_dv"}, dv_out, 1); check({tag, "_b_ch"}, chan_out, cb); check({tag, "_b_data"}, data_out, db);
    tick(3);
  endtask

  task automatic clear_ovf();
    ovf_clr_in = 1; tick(); ovf_clr_in = 0;
  endtask

  int n_dv;
  int drain_order[8] = '{0, 4, 1, 5, 2, 6, 3, 7};

  initial begin
    tick(3);
    n_reset_in = 1;
    @(negedge clk_in);
    check("rst_dv", dv_out, 0); check("rst_ch", chan_out, 0); check("rst_data", data_out, 0);
    check("rst_cnt", drop_cnt_out, 0); check("rst_ovf", ovf_out, 0);
    tick();

    latency_strobe("basic", 3'd0, 18'h1FFFF, 3'd4, 18'h20000);
    check("basic_ovf", ovf_out, 0);

    chan_en_in = 8'h0F; n_dv = 0;
    dv_in = 1; chan_a_in = 1; chan_b_in = 5; data_a_in = 18'h00123; data_b_in = 18'h3FFFF;
    tick(); dv_in = 0;
    repeat (6) begin @(negedge clk_in); if (dv_out) n_dv++; end
    check("mask_dv_cycles", n_dv, 1);
    check("mask_drop", drop_cnt_out, 0);
    tick(); chan_en_in = '1;

    ready_in = 0;
    for (int k = 0; k < 5; k++) begin
      strobe(W_CHAN'(k), W_CHAN'(k + 4));
      tick(16);
    end
    @(negedge clk_in);
    check("bp_drop", drop_cnt_out, 2); check("bp_ovf", ovf_out, 1); check("bp_dv", dv_out, 1);
    tick(); ready_in = 1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk_in);
      check("drain_order", chan_out, drain_order[i]);
    end
    tick(3);

    clear_ovf();
    ready_in = 0;
    for (int k = 0; k < 4; k++) strobe(W_CHAN'(k), W_CHAN'(7 - k));
    ready_in = 1; dv_in = 1; chan_a_in = 2; chan_b_in = 3;
    data_a_in = W_DATA'($urandom); data_b_in = W_DATA'($urandom);
    tick(); dv_in = 0; tick();
    @(negedge clk_in);
    check("popfull_drop", drop_cnt_out, 0); check("popfull_ovf", ovf_out, 0);
    tick(14);

    dv_in = 1; chan_a_in = 1; chan_b_in = 2; data_a_in = W_DATA'($urandom); data_b_in = W_DATA'($urandom);
    tick();
    chan_a_in = 3; chan_b_in = 5; data_a_in = W_DATA'($urandom); data_b_in = W_DATA'($urandom);
    tick(); dv_in = 0; tick(4);
    @(negedge clk_in);
    check("ovr_drop", drop_cnt_out, 2); check("ovr_ovf", ovf_out, 1);
    tick();
    dv_in = 1; tick(); ovf_clr_in = 1; tick(); dv_in = 0; ovf_clr_in = 0; tick();
    @(negedge clk_in);
    check("clr_drop", drop_cnt_out, 0); check("clr_ovf", ovf_out, 0);
    tick(4);

    ready_in = 0;
    strobe(0, 1); strobe(2, 3);
    chan_en_in = 8'h0F; dv_in = 1; chan_a_in = 6; chan_b_in = 7;
    tick(2); dv_in = 0; chan_en_in = '1; tick();
    @(negedge clk_in);
    check("pre_rst_drop", drop_cnt_out, 2); check("pre_rst_dv", dv_out, 1);
    tick(); n_reset_in = 0; tick(); n_reset_in = 1;
    @(negedge clk_in);
    check("mid_rst_dv", dv_out, 0); check("mid_rst_ch", chan_out, 0); check("mid_rst_data", data_out, 0);
    check("mid_rst_cnt", drop_cnt_out, 0); check("mid_rst_ovf", ovf_out, 0);
    tick(); ready_in = 1; tick();
    latency_strobe("post_rst", 3'd5, W_DATA'($urandom), 3'd2, W_DATA'($urandom));

    for (int i = 0; i < 500; i++) begin
      dv_in = ($urandom_range(0, 3) == 0);
      chan_a_in = W_CHAN'($urandom); chan_b_in = W_CHAN'($urandom);
      data_a_in = W_DATA'($urandom); data_b_in = W_DATA'($urandom);
      ready_in = ($urandom_range(0, 9) < 7);
      ovf_clr_in = ($urandom_range(0, 63) == 0);
      if (i % 100 == 0) chan_en_in = N_CHAN'($urandom);
      tick();
    end
    dv_in = 0; ovf_clr_in = 0; chan_en_in = '1; ready_in = 1;
    tick(20);

    clear_ovf();
    ready_in = 0;
    for (int i = 0; i < 600; i++) begin
      dv_in = 1; chan_a_in = W_CHAN'($urandom); chan_b_in = W_CHAN'($urandom);
      data_a_in = W_DATA'($urandom); data_b_in = W_DATA'($urandom);
      tick();
    end
    dv_in = 0; tick(2);
    @(negedge clk_in);
    check("sat_drop", drop_cnt_out, CNT_MAX); check("sat_ovf", ovf_out, 1);
    tick(); clear_ovf();
    @(negedge clk_in);
    check("sat_clr", drop_cnt_out, 0);
    tick(); ready_in = 1; tick(20);
    @(negedge clk_in);
    check("final_queue_empty", exp_q.size(), 0);
    check("final_dv", dv_out, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
